muldiv_unit: RTL
================

Name: muldiv_unit

Overview:
- Multi-cycle integer multiply/divide unit covering the RV64M/RV32M operations, including the W (32-bit) forms.
- Sits beside the single-cycle combinational ALU in the execute stage. Decode steers M-extension ops here and stalls issue on in_ready.
- Multiply uses a pipelined product with fixed latency. Divide is an iterative radix-2 restoring divider with sign fix-up.
- Valid/ready handshake on both sides, one operation in flight, tag passthrough for writeback.

Parameters:
- XLEN, 64, datapath width; legal values 32 or 64.
- MUL_LAT, 2, rising edges from acceptance to out_valid for multiply ops; legal range 1..4.
- TAG_W, 5, width of the opaque tag carried with each op (destination register index).

Ports:
- clk  input  1  clock, all state on rising edge
- reset_n  input  1  synchronous active-low reset
- flush  input  1  discard any in-flight op
- in_valid  input  1  operation request
- in_ready  output  1  unit can accept; high only in IDLE
- in_op  input  3  RISC-V funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
- in_is_w  input  1  W form; ignored when XLEN=32
- in_a  input  XLEN  rs1 value
- in_b  input  XLEN  rs2 value
- in_tag  input  TAG_W  passthrough tag
- out_valid  output  1  result available
- out_ready  input  1  consumer takes result
- out_result  output  XLEN  result
- out_tag  output  TAG_W  tag of the op that produced out_result
- busy  output  1  state != IDLE

Behaviour:
- Reset (reset_n=0 at an edge) puts the FSM in IDLE.
  - out_valid=0, out_result=0, out_tag=0, busy=0.
  - in_ready=1 from the first cycle after reset.
  - Reset mid-operation abandons the op with no output.
- Acceptance: an edge with in_valid && in_ready && !flush. Operands, op, is_w and tag are latched; inputs are don't-care afterwards.
- FSM states: IDLE, MUL, DSETUP, DITER, DFIX, DONE.
- Transitions:
  - IDLE -> MUL on accepting ops 0-3; IDLE -> DSETUP on accepting ops 4-7.
  - MUL holds MUL_LAT-1 cycles, then -> DONE.
  - DSETUP (1 cycle): capture absolute values, classify special cases -> DITER.
  - DITER iterates N cycles (N=XLEN, or 32 when is_w), then -> DFIX.
  - DFIX (1 cycle): apply sign and special-case overrides -> DONE.
  - DONE: out_valid=1; on out_ready -> IDLE.
- Latency, counted in edges from acceptance to out_valid rising:
  - multiply: MUL_LAT
  - divide: N+2, i.e. 66 for 64-bit and 34 for W or 32-bit.
- Back-to-back: in_ready is 0 in DONE. The next op is accepted at the edge after the out_ready handshake.
- Output stability: out_result and out_tag hold constant while out_valid && !out_ready. Both keep their last values after the handshake.
- W operand formation:
  - Signed operands take bits [31:0] sign-extended from bit 31; unsigned operands are zero-extended.
  - Final result is sign-extended from bit 31 of the 32-bit result.
  - in_is_w with op 1-3 behaves as MULW (low 32 bits of product, sign-extended).
- Multiply:
  - MUL returns the low XLEN bits of the 2*XLEN product.
  - MULH is signed x signed, MULHSU is signed rs1 x unsigned rs2, MULHU is unsigned x unsigned. All three return the high XLEN bits.
- Divide special cases (per RISC-V):
  - Divisor zero: quotient = all ones; remainder = dividend.
  - Signed overflow (most-negative / -1): quotient = dividend; remainder = 0.
  - Otherwise quotient truncates toward zero; remainder takes the sign of the dividend.
- Flush:
  - Priority order is reset_n, then flush, then everything else.
  - The next state is IDLE with out_valid=0. A result in DONE is dropped.
  - in_valid in the flush cycle is not accepted.
- No input-side error detection: every funct3 encoding is legal.

Optional Feature:
- Macro: MULDIV_EARLY_OUT_EN.
- Defined: divisor-zero and signed-overflow divides are resolved in DSETUP and go straight to DONE, so out_valid rises 1 edge after acceptance. Normal divides are unchanged.
- Undefined: special cases run the full N+2 sequence and are overridden in DFIX.
- Results are identical either way; only latency differs.

Test Plan:
- DIV a=-7, b=2, XLEN=64 -> out_result 0xFFFF_FFFF_FFFF_FFFD at edge 66. REM with the same operands -> 0xFFFF_FFFF_FFFF_FFFF.
- DIVU a=5, b=0 -> 0xFFFF_FFFF_FFFF_FFFF. REMU a=5, b=0 -> 5. With MULDIV_EARLY_OUT_EN, both arrive at edge 1, otherwise at edge 66.
- DIV a=0x8000_0000_0000_0000, b=-1 -> 0x8000_0000_0000_0000. REM with the same operands -> 0.
- MUL_LAT=2:
  - MULHU 0xFFFF_FFFF_FFFF_FFFF x 0xFFFF_FFFF_FFFF_FFFF -> 0xFFFF_FFFF_FFFF_FFFE at edge 2.
  - MULHSU a=-1, b=2 -> 0xFFFF_FFFF_FFFF_FFFF.
  - MUL tag=17 -> out_tag 17.
- W forms:
  - DIVW a=0x0000_0001_8000_0000, b=0xFFFF_FFFF -> 0xFFFF_FFFF_8000_0000 at edge 34.
  - MULW a=0x7FFF_FFFF, b=2 -> 0xFFFF_FFFF_FFFF_FFFE.
- Handshake and flush:
  - Hold out_ready=0 for 5 cycles in DONE -> result and tag stable, in_ready=0. out_ready=1 -> in_ready=1 next cycle.
  - Assert flush at edge 10 of a DIV -> out_valid never rises; in_ready=1 the next cycle.
  - Assert reset_n=0 mid-DIV -> all outputs return to reset values.

Source files
------------

// File: rtl/muldiv_unit.sv
// Multi-cycle RV64M/RV32M multiply/divide unit: fixed-latency multiply, radix-2 restoring divide.
// Optional MULDIV_EARLY_OUT_EN: divide-by-zero and signed-overflow divides complete straight from DSETUP.
module muldiv_unit #(
    parameter int XLEN    = 64,
    parameter int MUL_LAT = 2,
    parameter int TAG_W   = 5
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic             in_is_w,
    input  logic [XLEN-1:0]  in_a,
    input  logic [XLEN-1:0]  in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_result,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy,
    output logic [2:0]       dbg_state
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] MUL    = 3'd1;
    localparam logic [2:0] DSETUP = 3'd2;
    localparam logic [2:0] DITER  = 3'd3;
    localparam logic [2:0] DFIX   = 3'd4;
    localparam logic [2:0] DONE   = 3'd5;
    localparam int CW = $clog2(XLEN);

    // Handshake: a transfer happens on a rising edge where valid && ready are both high
    // (and flush is low). Valid, once raised, holds with stable payload until that edge.
    logic [2:0]       state;
    logic [1:0]       op_r;
    logic             w_r;
    logic [XLEN-1:0]  a_r, b_r;
    logic [TAG_W-1:0] tag_r;
    logic [CW-1:0]    cnt;
    logic [XLEN-1:0]  rem_r, quo_r;

    function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
        logic [XLEN-1:0] r;
        r = {XLEN{v[31]}};
        r[31:0] = v;
        return r;
    endfunction

    function automatic logic [XLEN-1:0] zext32(input logic [31:0] v);
        logic [XLEN-1:0] r;
        r = '0;
        r[31:0] = v;
        return r;
    endfunction

    logic w_eff;
    assign w_eff = (XLEN == 64) && w_r;

    // Multiply: operands extended to 2*XLEN so one unsigned product serves all sign mixes.
    logic              sign_a_m, sign_b_m;
    logic [2*XLEN-1:0] ma, mb, prod;
    logic [XLEN-1:0]   mul_res;
    assign sign_a_m = (op_r == 2'd1) || (op_r == 2'd2);
    assign sign_b_m = (op_r == 2'd1);
    assign ma       = {{XLEN{sign_a_m & a_r[XLEN-1]}}, a_r};
    assign mb       = {{XLEN{sign_b_m & b_r[XLEN-1]}}, b_r};
    assign prod     = ma * mb;

    always_comb begin
        mul_res = prod[2*XLEN-1:XLEN];
        if (w_eff)
            mul_res = sext32(prod[31:0]);
        else if (op_r == 2'd0)
            mul_res = prod[XLEN-1:0];
    end

    // Divide operand formation, magnitudes and RISC-V special cases.
    logic            div_signed, is_rem;
    logic [XLEN-1:0] a_op, b_op, abs_a, abs_b, min_neg;
    logic            a_neg, b_neg, div_zero, div_ovf, early_out;
    assign div_signed = ~op_r[0];
    assign is_rem     = op_r[1];
    assign a_op    = w_eff ? (div_signed ? sext32(a_r[31:0]) : zext32(a_r[31:0])) : a_r;
    assign b_op    = w_eff ? (div_signed ? sext32(b_r[31:0]) : zext32(b_r[31:0])) : b_r;
    assign a_neg   = div_signed && a_op[XLEN-1];
    assign b_neg   = div_signed && b_op[XLEN-1];
    assign abs_a   = a_neg ? -a_op : a_op;
    assign abs_b   = b_neg ? -b_op : b_op;
    assign min_neg = w_eff ? sext32(32'h8000_0000) : {1'b1, {(XLEN-1){1'b0}}};
    assign div_zero = (b_op == '0);
    assign div_ovf  = div_signed && (a_op == min_neg) && (b_op == '1);

`ifdef MULDIV_EARLY_OUT_EN
    assign early_out = div_zero || div_ovf;
`else
    assign early_out = 1'b0;
`endif

    // One restoring step: shift the next dividend bit into the partial remainder.
    logic [XLEN:0]   rem_sh;
    logic [XLEN-1:0] rem_diff;
    logic            rem_ge;
    assign rem_sh   = {rem_r, quo_r[XLEN-1]};
    assign rem_ge   = rem_sh[XLEN] || (rem_sh[XLEN-1:0] >= abs_b);
    assign rem_diff = rem_sh[XLEN-1:0] - abs_b;

    logic [XLEN-1:0] q_fix, r_fix, spec_res, div_raw, div_res;
    assign q_fix    = (a_neg ^ b_neg) ? -quo_r : quo_r;
    assign r_fix    = a_neg ? -rem_r : rem_r;
    assign spec_res = div_zero ? (is_rem ? a_op : '1) : (is_rem ? '0 : a_op);
    assign div_raw  = (div_zero || div_ovf) ? spec_res : (is_rem ? r_fix : q_fix);
    assign div_res  = w_eff ? sext32(div_raw[31:0]) : div_raw;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= IDLE;
            op_r       <= '0;
            w_r        <= 1'b0;
            a_r        <= '0;
            b_r        <= '0;
            tag_r      <= '0;
            cnt        <= '0;
            rem_r      <= '0;
            quo_r      <= '0;
            out_result <= '0;
            out_tag    <= '0;
        end else if (flush) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        op_r  <= in_op[1:0];
                        w_r   <= in_is_w;
                        a_r   <= in_a;
                        b_r   <= in_b;
                        tag_r <= in_tag;
                        cnt   <= CW'(MUL_LAT - 1);
                        state <= in_op[2] ? DSETUP : MUL;
                    end
                end
                MUL: begin
                    if (cnt == '0) begin
                        out_result <= mul_res;
                        out_tag    <= tag_r;
                        state      <= DONE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                DSETUP: begin
                    if (early_out) begin
                        out_result <= div_res;
                        out_tag    <= tag_r;
                        state      <= DONE;
                    end else begin
                        rem_r <= '0;
                        quo_r <= w_eff ? (abs_a << 32) : abs_a;
                        cnt   <= w_eff ? CW'(31) : CW'(XLEN - 1);
                        state <= DITER;
                    end
                end
                DITER: begin
                    rem_r <= rem_ge ? rem_diff : rem_sh[XLEN-1:0];
                    quo_r <= {quo_r[XLEN-2:0], rem_ge};
                    cnt   <= cnt - 1'b1;
                    if (cnt == '0)
                        state <= DFIX;
                end
                DFIX: begin
                    out_result <= div_res;
                    out_tag    <= tag_r;
                    state      <= DONE;
                end
                DONE: begin
                    if (out_ready)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign dbg_state = state;

endmodule
